// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the miner host-link serial transmitter.
package serial_pkg;

   localparam int DEF_CLKS_PER_BIT = 100;  // 50 MHz / 500 kbps

   localparam logic FRAME_START_BIT = 1'b0;
   localparam logic FRAME_STOP_BIT  = 1'b1;
   localparam int   FRAME_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 shifter. A start accepted on the stop-bit wrap chains the next byte with no idle gap.
module uart_tx_byte
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_start,
   input  logic [FRAME_DATA_BITS-1:0] i_data,
   output logic                       o_txd,
   output logic                       o_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(FRAME_DATA_BITS - 1);

   tx_state_t                  r_state;
   logic [CW-1:0]              r_cnt;
   logic [2:0]                 r_bit_idx;
   logic [FRAME_DATA_BITS-1:0] r_shift;
   logic                       r_txd;
   logic                       w_wrap;

   assign w_wrap = (r_cnt == LAST_CNT);
   assign o_done = (r_state == STOP) && w_wrap;
   assign o_txd  = r_txd;

   // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= FRAME_STOP_BIT;
      end else begin
         r_cnt <= (r_state == IDLE || w_wrap) ? '0 : r_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_shift <= i_data;
                  r_txd   <= FRAME_START_BIT;
                  r_state <= START;
               end
            end
            START: begin
               if (w_wrap) begin
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_wrap) begin
                  if (r_bit_idx == LAST_BIT) begin
                     r_txd   <= FRAME_STOP_BIT;
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shift   <= r_shift >> 1;
                     r_txd     <= r_shift[1];
                  end
               end
            end
            STOP: begin
               if (w_wrap) begin
                  if (i_start) begin
                     r_shift <= i_data;
                     r_txd   <= FRAME_START_BIT;
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_nonce_tx.sv
// Golden-nonce serial transmitter: valid/ready intake, LSB-byte-first 8N1 frames on TxD.
// Define SERIAL_TX_FIFO_EN for a FIFO_DEPTH-entry nonce queue; default is a single capture register.
module serial_nonce_tx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int NONCE_BYTES  = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [8*NONCE_BYTES-1:0] nonce,
   input  logic                     nonce_valid,
   output logic                     nonce_ready,
   output logic                     TxD,
   output logic                     tx_busy
);

   localparam int NW = 8 * NONCE_BYTES;
   localparam int BW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NONCE_BYTES - 1);

   logic          r_busy;
   logic [BW-1:0] r_byte_idx;
   logic [NW-1:0] r_rest;
   logic          w_accept;
   logic          w_done;
   logic          w_last_done;
   logic          w_launch;
   logic          w_start;
   logic [NW-1:0] w_launch_data;
   logic [7:0]    w_byte;

   assign w_accept    = nonce_valid & nonce_ready;
   assign w_last_done = w_done & (r_byte_idx == LAST_BYTE);

`ifdef SERIAL_TX_FIFO_EN
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [NW-1:0] r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_free;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_free        = ~r_busy | w_last_done;
   assign w_empty       = (r_count == '0);
   assign nonce_ready   = (r_count != (PW+1)'(FIFO_DEPTH));
   assign w_pop         = w_free & ~w_empty;
   // An empty queue with a free line bypasses straight to the shifter to keep one-cycle latency.
   assign w_push        = w_accept & ~(w_empty & w_free);
   assign w_launch      = w_pop | (w_accept & w_empty & w_free);
   assign w_launch_data = w_empty ? nonce : r_fifo[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // NOTE: queue storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= nonce;
   end
`else
   assign nonce_ready   = ~r_busy;
   assign w_launch      = w_accept;
   assign w_launch_data = nonce;
`endif

   assign w_start = w_launch | (w_done & ~w_last_done);
   assign w_byte  = w_launch ? w_launch_data[7:0] : r_rest[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy     <= 1'b0;
         r_byte_idx <= '0;
         r_rest     <= '0;
      end else if (w_launch) begin
         r_busy     <= 1'b1;
         r_byte_idx <= '0;
         r_rest     <= w_launch_data >> 8;
      end else if (w_done) begin
         if (w_last_done) begin
            r_busy <= 1'b0;
         end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
            r_rest     <= r_rest >> 8;
         end
      end
   end

   assign tx_busy = r_busy;

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_data  (w_byte),
      .o_txd   (TxD),
      .o_done  (w_done)
   );

endmodule

// File: tb/tb_serial_nonce_tx.sv
// Self-checking bench for serial_nonce_tx: table-driven frame vectors plus reset, back-to-back and loopback sequences.
module tb_serial_nonce_tx;

   localparam int CPB   = 100;
   localparam int FRAME = 4 * 10 * CPB;

   typedef struct {
      logic [31:0] nonce;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] nonce;
   logic        nonce_valid;
   logic        nonce_ready;
   logic        TxD;
   logic        tx_busy;

   int checks = 0;
   int errors = 0;

   logic smp_txd   [0:2*FRAME+1];
   logic smp_busy  [0:2*FRAME+1];
   logic smp_ready [0:2*FRAME+1];

   vec_t        vecs [4];
   logic [31:0] val;
   int          ferr;
   int          bad;
   logic        ok;
   logic [7:0]  rb;
   logic        rferr;
   logic        exp_ready1;

   always #5 clk = ~clk;

   serial_nonce_tx #(
      .CLKS_PER_BIT (CPB),
      .NONCE_BYTES  (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .nonce       (nonce),
      .nonce_valid (nonce_valid),
      .nonce_ready (nonce_ready),
      .TxD         (TxD),
      .tx_busy     (tx_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Raise valid with n and wait until ready is seen; the accept edge is the next posedge.
   task automatic offer(input logic [31:0] n, input int budget, output logic acc);
      @(negedge clk);
      nonce       = n;
      nonce_valid = 1'b1;
      acc         = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (nonce_ready === 1'b1) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!acc) check("offer_timeout", 32'(nonce_ready), 32'd1);
   endtask

   // Index k holds cycle N+k, where N is the accept cycle.
   task automatic record(input int len, input logic hold, input logic [31:0] next_n, input int drop_at);
      @(posedge clk);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         smp_txd[k]   = TxD;
         smp_busy[k]  = tx_busy;
         smp_ready[k] = nonce_ready;
         if (k == 1) begin
            if (hold) begin
               nonce = next_n;
            end else begin
               nonce_valid = 1'b0;
               nonce       = 32'ha5a5_5a5a;
            end
         end
         if (k == drop_at) nonce_valid = 1'b0;
      end
   endtask

   // Mid-bit decode of one 4-byte frame whose start bit begins at sample index b0.
   task automatic decode(input int b0, output logic [31:0] v, output int fe);
      int base;
      v  = '0;
      fe = 0;
      for (int j = 0; j < 4; j++) begin
         base = b0 + j * 10 * CPB;
         if (smp_txd[base + CPB/2] !== 1'b0) fe++;
         for (int i = 0; i < 8; i++) v[8*j + i] = smp_txd[base + CPB*(i+1) + CPB/2];
         if (smp_txd[base + 9*CPB + CPB/2] !== 1'b1) fe++;
      end
   endtask

   // Live line receiver: waits for a start bit and samples at bit centres.
   task automatic rx_byte(output logic [7:0] b, output logic fe);
      int n;
      n  = 0;
      fe = 1'b0;
      b  = '0;
      do begin
         @(negedge clk);
         n++;
      end while (TxD !== 1'b0 && n < 3*FRAME);
      if (TxD !== 1'b0) begin
         fe = 1'b1;
         return;
      end
      repeat (CPB/2 - 1) @(negedge clk);
      if (TxD !== 1'b0) fe = 1'b1;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = TxD;
      end
      repeat (CPB) @(negedge clk);
      if (TxD !== 1'b1) fe = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SERIAL_TX_FIFO_EN
      exp_ready1 = 1'b1;
`else
      exp_ready1 = 1'b0;
`endif
      vecs[0] = '{32'h1afda099, 8'h99, 8'ha0, 8'hfd, 8'h1a};
      vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{32'hffffffff, 8'hff, 8'hff, 8'hff, 8'hff};
      vecs[3] = '{32'h80017f80, 8'h80, 8'h7f, 8'h01, 8'h80};

      reset       = 1'b0;
      nonce_valid = 1'b0;
      nonce       = '0;
      #1 reset = 1'b1;
      #1;
      check("reset_txd",   32'(TxD),         32'd1);
      check("reset_ready", 32'(nonce_ready), 32'd1);
      check("reset_busy",  32'(tx_busy),     32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1 || nonce_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("idle_1000_violations", 32'(bad), 32'd0);

      // Table-driven single frames
      for (int v = 0; v < 4; v++) begin
         offer(vecs[v].nonce, 100, ok);
         record(FRAME + 1, 1'b0, 32'h0, 0);
         decode(1, val, ferr);
         check($sformatf("v%0d_bytes", v), val, {vecs[v].b3, vecs[v].b2, vecs[v].b1, vecs[v].b0});
         check($sformatf("v%0d_framing", v), 32'(ferr), 32'd0);
         check($sformatf("v%0d_start_first", v), 32'(smp_txd[1]),   32'd0);
         check($sformatf("v%0d_start_last", v),  32'(smp_txd[100]), 32'd0);
         check($sformatf("v%0d_bit0_first", v),  32'(smp_txd[101]), 32'(vecs[v].b0[0]));
         check($sformatf("v%0d_stop_first", v),  32'(smp_txd[901]), 32'd1);
         check($sformatf("v%0d_stop_last", v),   32'(smp_txd[1000]), 32'd1);
         check($sformatf("v%0d_byte1_start", v), 32'(smp_txd[1001]), 32'd0);
         check($sformatf("v%0d_busy_first", v),  32'(smp_busy[1]),    32'd1);
         check($sformatf("v%0d_busy_last", v),   32'(smp_busy[FRAME]), 32'd1);
         check($sformatf("v%0d_busy_fall", v),   32'(smp_busy[FRAME+1]), 32'd0);
         check($sformatf("v%0d_line_idle", v),   32'(smp_txd[FRAME+1]),  32'd1);
         check($sformatf("v%0d_ready_during", v), 32'(smp_ready[1]),     32'(exp_ready1));
         check($sformatf("v%0d_ready_after", v),  32'(smp_ready[FRAME+1]), 32'd1);
      end

      // Two nonces offered back-to-back
      offer(32'h00000001, 100, ok);
`ifdef SERIAL_TX_FIFO_EN
      record(2*FRAME + 1, 1'b1, 32'hdeadbeef, 2);
      decode(1, val, ferr);
      check("b2b_first", val, 32'h00000001);
      decode(FRAME + 1, val, ferr);
      check("b2b_second", val, 32'hdeadbeef);
      check("b2b_no_gap_stop", 32'(smp_txd[FRAME]),     32'd1);
      check("b2b_no_gap_start", 32'(smp_txd[FRAME+1]),  32'd0);
      check("b2b_busy_held", 32'(smp_busy[FRAME+1]),    32'd1);
      check("b2b_busy_fall", 32'(smp_busy[2*FRAME+1]),  32'd0);
`else
      record(FRAME + 1, 1'b1, 32'hdeadbeef, 0);
      decode(1, val, ferr);
      check("b2b_first", val, 32'h00000001);
      bad = 0;
      for (int k = 1; k <= FRAME; k++) if (smp_ready[k] !== 1'b0) bad++;
      check("b2b_ready_low_while_busy", 32'(bad), 32'd0);
      check("b2b_ready_at_idle", 32'(smp_ready[FRAME+1]), 32'd1);
      record(FRAME + 1, 1'b0, 32'h0, 0);
      decode(1, val, ferr);
      check("b2b_second", val, 32'hdeadbeef);
      check("b2b_second_framing", 32'(ferr), 32'd0);
      check("b2b_second_busy_fall", 32'(smp_busy[FRAME+1]), 32'd0);
`endif

      // Reset in the middle of byte 0, bit 3 (a zero bit of 0xf0)
      offer(32'h000000f0, 100, ok);
      @(posedge clk);
      for (int k = 1; k <= 450; k++) begin
         @(negedge clk);
         if (k == 1) nonce_valid = 1'b0;
      end
      check("midrst_pre_txd", 32'(TxD), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("midrst_txd",   32'(TxD),         32'd1);
      check("midrst_busy",  32'(tx_busy),     32'd0);
      check("midrst_ready", 32'(nonce_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("midrst_quiet_violations", 32'(bad), 32'd0);

      // Loopback into a line receiver
      offer(32'h3c96e10f, 100, ok);
      @(posedge clk);
      #1 nonce_valid = 1'b0;
      rx_byte(rb, rferr);
      check("loop_b0", 32'(rb), 32'h0f);
      check("loop_b0_ferr", 32'(rferr), 32'd0);
      rx_byte(rb, rferr);
      check("loop_b1", 32'(rb), 32'he1);
      rx_byte(rb, rferr);
      check("loop_b2", 32'(rb), 32'h96);
      rx_byte(rb, rferr);
      check("loop_b3", 32'(rb), 32'h3c);
      check("loop_b3_ferr", 32'(rferr), 32'd0);
      bad = 0;
      while (tx_busy === 1'b1 && bad < 2*CPB) begin
         @(negedge clk);
         bad++;
      end
      check("loop_busy_fall", 32'(tx_busy), 32'd0);

`ifdef SERIAL_TX_FIFO_EN
      // Six nonces offered continuously: queue fills, all drain in order
      begin
         logic [31:0] seq [6];
         seq[0] = 32'h11111111; seq[1] = 32'h22222222; seq[2] = 32'h33333333;
         seq[3] = 32'h44444444; seq[4] = 32'h55555555; seq[5] = 32'h66666666;
         fork
            begin : drv
               logic acc;
               for (int i = 0; i < 6; i++) begin
                  offer(seq[i], 3*FRAME, acc);
                  @(posedge clk);
                  #1 nonce_valid = 1'b0;
                  if (i == 4) begin
                     @(negedge clk);
                     check("fifo_full_ready", 32'(nonce_ready), 32'd0);
                  end
               end
            end
            begin : rcv
               logic [7:0]  b;
               logic        fe;
               logic [31:0] w;
               int          fes;
               for (int i = 0; i < 6; i++) begin
                  fes = 0;
                  for (int j = 0; j < 4; j++) begin
                     rx_byte(b, fe);
                     w[8*j +: 8] = b;
                     if (fe) fes++;
                  end
                  check($sformatf("fifo_frame%0d", i), w, seq[i]);
                  check($sformatf("fifo_frame%0d_ferr", i), 32'(fes), 32'd0);
               end
            end
         join
         bad = 0;
         while (tx_busy === 1'b1 && bad < 2*CPB) begin
            @(negedge clk);
            bad++;
         end
         check("fifo_drained_busy", 32'(tx_busy), 32'd0);
         check("fifo_drained_ready", 32'(nonce_ready), 32'd1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
